// File: rtl/muldiv_div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) using radix-2 restoring division.
// Holds the EX instruction via DivBusy until the result strobes out on DivDone.
module muldiv_div_unit #(
  parameter int unsigned XLEN      = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StartE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            DivBusy,
  output logic            DivDone,
  output logic [XLEN-1:0] DivResult
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d;       // dividend, then quotient shift register
  logic [XLEN-1:0] b_q, b_d;       // divisor (magnitude after PREP)
  logic [XLEN-1:0] r_q, r_d;       // partial remainder
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      f3_q, f3_d;     // bit0: unsigned op, bit1: remainder select
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            done_q, done_d;

  logic            start_c;
  logic            is_signed_c;
  logic            b_zero_c;
  logic            ovf_c;
  logic [XLEN-1:0] a_abs_c;
  logic [XLEN-1:0] b_abs_c;
  logic [XLEN:0]   shifted_c;
  logic [XLEN+1:0] trial_c;
  logic            borrow_c;
  logic [XLEN-1:0] q_fix_c;
  logic [XLEN-1:0] r_fix_c;
  logic            busy_c;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      f3_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  // Arithmetic helpers shared by the FSM
  always_comb begin
    start_c     = StartE & Funct3E[2] & ~FlushE;
    is_signed_c = ~f3_q[0];
    b_zero_c    = (b_q == '0);
    ovf_c       = is_signed_c && (a_q == MIN_NEG) && (b_q == '1);
    a_abs_c     = (is_signed_c && a_q[XLEN-1]) ? -a_q : a_q;
    b_abs_c     = (is_signed_c && b_q[XLEN-1]) ? -b_q : b_q;
    shifted_c   = {r_q, a_q[XLEN-1]};
    trial_c     = {1'b0, shifted_c} - {2'b00, b_q};
    borrow_c    = trial_c[XLEN+1];
    q_fix_c     = negq_q ? -a_q : a_q;
    r_fix_c     = negr_q ? -r_q : r_q;
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    res_d   = res_q;
    done_d  = 1'b0;
    busy_c  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_c = start_c;
        if (start_c) begin
          a_d     = SrcAE;
          b_d     = SrcBE;
          f3_d    = Funct3E[1:0];
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        busy_c  = 1'b1;
        // Divide-by-zero must yield an all-ones quotient even for signed ops
        negq_d  = is_signed_c & (a_q[XLEN-1] ^ b_q[XLEN-1]) & ~b_zero_c;
        negr_d  = is_signed_c & a_q[XLEN-1];
        a_d     = a_abs_c;
        b_d     = b_abs_c;
        r_d     = '0;
        cnt_d   = CW'(XLEN - 1);
        state_d = S_CALC;
        if (EARLY_OUT && b_zero_c) begin
          res_d   = f3_q[1] ? a_q : '1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (EARLY_OUT && ovf_c) begin
          res_d   = f3_q[1] ? '0 : MIN_NEG;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_CALC: begin
        busy_c = 1'b1;
        r_d    = borrow_c ? shifted_c[XLEN-1:0] : trial_c[XLEN-1:0];
        a_d    = {a_q[XLEN-2:0], ~borrow_c};
        cnt_d  = CW'(cnt_q - 1'b1);
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        busy_c  = 1'b1;
        res_d   = f3_q[1] ? r_fix_c : q_fix_c;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A killed EX instruction abandons the operation and keeps the old result
    if (FlushE) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      res_d   = res_q;
      busy_c  = 1'b0;
    end
  end

  // Stall request is combinational and suppressed while in reset
  assign DivBusy   = busy_c & rst;
  assign DivDone   = done_q;
  assign DivResult = res_q;

endmodule

// File: tb/tb_muldiv_div_unit.sv
// Directed bench for muldiv_div_unit; runs EARLY_OUT=1 and EARLY_OUT=0 instances in lockstep.
module tb_muldiv_div_unit;

  logic        clk;
  logic        rst;
  logic        StartE;
  logic [2:0]  Funct3E;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        FlushE;
  logic        busy1, done1, busy0, done0;
  logic [31:0] res1, res0;

  int checks;
  int errors;

  muldiv_div_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .StartE(StartE), .Funct3E(Funct3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE),
    .DivBusy(busy1), .DivDone(done1), .DivResult(res1)
  );

  muldiv_div_unit #(.XLEN(32), .EARLY_OUT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .StartE(StartE), .Funct3E(Funct3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE),
    .DivBusy(busy0), .DivDone(done0), .DivResult(res0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a start in cycle T, check the stall request, then scramble inputs in T+1
  task automatic start_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b);
    StartE  = 1'b1;
    Funct3E = f3;
    SrcAE   = a;
    SrcBE   = b;
    #1;
    chk({tag, " busy@T eo1"}, {31'b0, busy1}, 32'd1);
    chk({tag, " busy@T eo0"}, {31'b0, busy0}, 32'd1);
    @(posedge clk);
    #1;
    StartE  = 1'b0;
    Funct3E = 3'b100;
    SrcAE   = 32'h1234_5678;
    SrcBE   = 32'h0000_0003;
  endtask

  // Wait (bounded) for both instances to strobe done, then check latency and result
  task automatic wait_both(input string tag, input logic [31:0] exp, input int lat1);
    int          k;
    bit          s0, s1, bok;
    int          l0, l1;
    logic [31:0] r0, r1;
    k = 1; s0 = 0; s1 = 0; bok = 1; l0 = -1; l1 = -1; r0 = '0; r1 = '0;
    while (!(s0 && s1) && k < 60) begin
      if (!s1) begin
        if (done1) begin
          s1 = 1; l1 = k; r1 = res1;
          if (busy1) bok = 0;
        end else if (!busy1) bok = 0;
      end
      if (!s0) begin
        if (done0) begin
          s0 = 1; l0 = k; r0 = res0;
          if (busy0) bok = 0;
        end else if (!busy0) bok = 0;
      end
      step();
      k++;
    end
    chk({tag, " lat eo1"}, 32'(l1), 32'(lat1));
    chk({tag, " lat eo0"}, 32'(l0), 32'd35);
    chk({tag, " res eo1"}, r1, exp);
    chk({tag, " res eo0"}, r0, exp);
    chk({tag, " busy profile"}, {31'b0, bok}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat1);
    start_op(tag, f3, a, b);
    wait_both(tag, exp, lat1);
  endtask

  initial begin
    bit saw_done;
    checks  = 0;
    errors  = 0;
    clk     = 1'b0;
    rst     = 1'b0;
    StartE  = 1'b0;
    Funct3E = 3'b000;
    SrcAE   = '0;
    SrcBE   = '0;
    FlushE  = 1'b0;
    #12;
    chk("reset busy", {30'b0, busy1, busy0}, 32'd0);
    chk("reset done", {30'b0, done1, done0}, 32'd0);
    chk("reset res eo1", res1, 32'd0);
    chk("reset res eo0", res0, 32'd0);
    rst = 1'b1;
    step();

    // StartE together with FlushE in IDLE must not start
    StartE = 1'b1; FlushE = 1'b1; Funct3E = 3'b101; SrcAE = 32'd100; SrcBE = 32'd7;
    #1;
    chk("start+flush busy@T", {30'b0, busy1, busy0}, 32'd0);
    @(posedge clk); #1;
    StartE = 1'b0; FlushE = 1'b0;
    chk("start+flush busy@T+1", {30'b0, busy1, busy0}, 32'd0);
    step();
    chk("start+flush done", {30'b0, done1, done0}, 32'd0);

    run_op("DIVU 100/7",  3'b101, 32'd100,       32'd7,         32'd14,        35);
    run_op("REMU 100/7",  3'b111, 32'd100,       32'd7,         32'd2,         35);
    run_op("DIV -7/2",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 35);
    run_op("REM -7/2",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 35);
    run_op("REM 7/-2",    3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         35);

    // Flush at T+10 aborts; restart at T+12 completes at T+47
    start_op("flush", 3'b101, 32'd100, 32'd7);
    saw_done = 0;
    repeat (9) begin
      if (done1 || done0) saw_done = 1;
      step();
    end
    FlushE = 1'b1;
    #1;
    chk("flush busy@T+10", {30'b0, busy1, busy0}, 32'd0);
    @(posedge clk); #1;
    FlushE = 1'b0;
    if (done1 || done0) saw_done = 1;
    chk("flush busy@T+11", {30'b0, busy1, busy0}, 32'd0);
    chk("flush no done", {31'b0, saw_done}, 32'd0);
    chk("flush res hold eo1", res1, 32'd1);
    chk("flush res hold eo0", res0, 32'd1);
    step();
    run_op("post-flush DIVU 9/3", 3'b101, 32'd9, 32'd3, 32'd3, 35);

    run_op("DIVU 5/0",    3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 2);
    run_op("REMU 5/0",    3'b111, 32'd5,         32'd0,         32'd5,         2);
    run_op("DIV -7/0",    3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 2);
    run_op("REM -7/0",    3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 2);
    run_op("DIV ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run_op("REM ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2);
    run_op("DIVU max/1",  3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 35);
    run_op("DIVU 2^31/max", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       35);
    run_op("REMU 2^31/max", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35);

    // Async reset mid-CALC clears outputs immediately
    start_op("reset mid", 3'b101, 32'd100, 32'd7);
    repeat (19) step();
    rst = 1'b0;
    #1;
    chk("midreset busy", {30'b0, busy1, busy0}, 32'd0);
    chk("midreset done", {30'b0, done1, done0}, 32'd0);
    chk("midreset res eo1", res1, 32'd0);
    chk("midreset res eo0", res0, 32'd0);
    step();
    rst = 1'b1;
    step();
    run_op("post-reset DIVU 9/3", 3'b101, 32'd9, 32'd3, 32'd3, 35);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
